sevenseg_scan: RTL and testbench

- Time-multiplexed scan controller that produces the `led`, `x` and `dot` inputs consumed by the four-digit seven-segment decoder/anode driver.
- Steps a 2-bit digit select at a fixed refresh rate.
- Presents the matching BCD digit from an HH:MM value, snapshotted once per frame so a display frame never mixes old and new digits.
- Drives the hours/minutes separator dot: off, on, or blinking.

---
 rtl/sevenseg_pkg.sv | 21 ++
 rtl/tick_gen.sv | 29 ++
 rtl/sevenseg_scan.sv | 82 ++++++++
 tb/tb_sevenseg_scan.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared codes for the seven-segment scan path: digit-select codes, dot modes
// and the BCD clamp applied to live digits before they reach the decoder.
package sevenseg_pkg;

  localparam logic [1:0] LED_HT = 2'b00;
  localparam logic [1:0] LED_HU = 2'b01;
  localparam logic [1:0] LED_MT = 2'b10;
  localparam logic [1:0] LED_MU = 2'b11;

  localparam logic [1:0] DOT_OFF   = 2'b00;
  localparam logic [1:0] DOT_ON    = 2'b01;
  localparam logic [1:0] DOT_BLINK = 2'b10;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Codes 10..15 would freeze the decoder's segments, so they display as 0.
  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > BCD_MAX) ? 4'd0 : d;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: tick is high for one cycle every DIV cycles.
// Serves the digit scan here and the 1 Hz timekeeping tick elsewhere.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // With DIV = 1 the count sits at 0 == LAST, so tick is high every cycle.
  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sevenseg_scan.sv
// Four-digit scan controller: steps the digit select, presents a per-frame
// snapshot of HH:MM and drives the hours/minutes separator dot.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int STEP_HZ  = 1_000,
  parameter int BLINK_HZ = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hr_tens,
  input  logic [3:0] hr_units,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_units,
  input  logic [1:0] dot_mode,
  output logic [1:0] led,
  output logic [3:0] x,
  output logic       dot
);

  localparam int DIV         = CLK_HZ / STEP_HZ;
  localparam int BLINK_STEPS = STEP_HZ / (2 * BLINK_HZ);
  localparam int BW          = (BLINK_STEPS > 1) ? $clog2(BLINK_STEPS) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_STEPS - 1);

  logic          step;
  logic [3:0]    shadow [4];
  logic [3:0]    live   [4];
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [1:0]    led_n;
  logic          dot_en;

  tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (step)
  );

  always_comb begin
    led_n   = led + 2'd1;
    live[0] = clamp_bcd(hr_tens);
    live[1] = clamp_bcd(hr_units);
    live[2] = clamp_bcd(min_tens);
    live[3] = clamp_bcd(min_units);
    case (dot_mode)
      DOT_ON:    dot_en = 1'b1;
      DOT_BLINK: dot_en = blink_phase;
      default:   dot_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led         <= LED_HT;
      x           <= 4'd0;
      dot         <= 1'b0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      for (int i = 0; i < 4; i++) shadow[i] <= 4'd0;
    end else if (step) begin
      led <= led_n;
      // The frame snapshot is taken on the wrap; the first digit bypasses
      // the shadow so it is not a frame behind the other three.
      if (led_n == LED_HT) begin
        for (int i = 0; i < 4; i++) shadow[i] <= live[i];
        x <= live[LED_HT];
      end else begin
        x <= shadow[led_n];
      end
      dot <= (led_n == LED_HU) && dot_en;
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Bench for sevenseg_scan: a DIV=4 instance and a DIV=1 instance share the
// stimulus and are checked every cycle against a step-count reference model.
module tb_sevenseg_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] hr_tens, hr_units, min_tens, min_units;
  logic [1:0] dot_mode;
  logic [1:0] led_a, led_b;
  logic [3:0] x_a, x_b;
  logic       dot_a, dot_b;

  int vectors     = 0;
  int miscompares = 0;
  bit model_on    = 1'b0;

  always #5 clk = ~clk;

  // a: DIV = 4, BLINK_STEPS = 2.  b: DIV = 1, BLINK_STEPS = 4.
  sevenseg_scan #(.CLK_HZ(16), .STEP_HZ(4), .BLINK_HZ(1)) dut_a (
    .clk(clk), .rst(rst), .hr_tens(hr_tens), .hr_units(hr_units),
    .min_tens(min_tens), .min_units(min_units), .dot_mode(dot_mode),
    .led(led_a), .x(x_a), .dot(dot_a)
  );

  sevenseg_scan #(.CLK_HZ(8), .STEP_HZ(8), .BLINK_HZ(1)) dut_b (
    .clk(clk), .rst(rst), .hr_tens(hr_tens), .hr_units(hr_units),
    .min_tens(min_tens), .min_units(min_units), .dot_mode(dot_mode),
    .led(led_b), .x(x_b), .dot(dot_b)
  );

  // Reference model: everything derives from t, the edges since reset release.
  // Step s happens at edge s*DIV; the digit shown is s mod 4; the blink phase
  // seen by step s is floor((s-1)/BLINK_STEPS) mod 2.
  int         m_div [2] = '{4, 1};
  int         m_bs  [2] = '{2, 4};
  int         t     [2];
  logic [1:0] m_led [2];
  logic [3:0] m_x   [2];
  logic       m_dot [2];
  logic [3:0] snap  [2][4];
  logic [3:0] live  [4];
  int         s, l, ph;

  function automatic logic [3:0] clamp(input logic [3:0] d);
    if (d > 4'd9) return 4'd0;
    return d;
  endfunction

  always @(posedge clk) begin
    live[0] = clamp(hr_tens);
    live[1] = clamp(hr_units);
    live[2] = clamp(min_tens);
    live[3] = clamp(min_units);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        t[i] = 0; m_led[i] = 2'd0; m_x[i] = 4'd0; m_dot[i] = 1'b0;
        for (int k = 0; k < 4; k++) snap[i][k] = 4'd0;
      end else begin
        t[i] = t[i] + 1;
        if (t[i] % m_div[i] == 0) begin
          s  = t[i] / m_div[i];
          l  = s % 4;
          ph = ((s - 1) / m_bs[i]) % 2;
          if (l == 0) snap[i] = live;
          m_led[i] = 2'(l);
          m_x[i]   = snap[i][l];
          m_dot[i] = (l == 1) && ((dot_mode == 2'b01) || (dot_mode == 2'b10 && ph == 1));
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (model_on) begin
      chk("a.led", led_a, m_led[0]);
      chk("a.x",   x_a,   m_x[0]);
      chk("a.dot", dot_a, m_dot[0]);
      chk("b.led", led_b, m_led[1]);
      chk("b.x",   x_b,   m_x[1]);
      chk("b.dot", dot_b, m_dot[1]);
      chk("a.x_bcd", int'(x_a <= 4'd9), 1);
      chk("b.x_bcd", int'(x_b <= 4'd9), 1);
    end
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    {hr_tens, hr_units, min_tens, min_units} = '0;
    dot_mode = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    hr_tens = 4'd1; hr_units = 4'd2; min_tens = 4'd3; min_units = 4'd4;
    dot_mode = 2'b01;
    model_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // First frame shows zeros; live digits from the wrap at edge 16.
    adv(4);
    chk("lit.first_step_led", led_a, 1);
    chk("lit.first_frame_x", x_a, 0);
    chk("lit.first_step_dot", dot_a, 1);
    adv(12);
    chk("lit.wrap_led", led_a, 0);
    chk("lit.wrap_x", x_a, 1);
    chk("lit.div1_wrap_x", x_b, 1);
    adv(4);
    chk("lit.hu_x", x_a, 2);
    chk("lit.hu_dot", dot_a, 1);

    // Tearing: min_units changes while led = 01.
    @(negedge clk);
    min_units = 4'd7;
    adv(8);
    chk("lit.tear_led", led_a, 3);
    chk("lit.tear_x_old", x_a, 4);

    // Clamp: hr_tens = C at the next capture.
    @(negedge clk);
    hr_tens = 4'hC;
    adv(4);
    chk("lit.clamp_led", led_a, 0);
    chk("lit.clamp_x", x_a, 0);
    adv(12);
    chk("lit.tear_x_new", x_a, 7);

    // Blink mode, edge 44 onward.
    @(negedge clk);
    dot_mode = 2'b10;
    hr_tens  = 4'd1;
    adv(5);
    chk("lit.blink_b_led", led_b, 1);
    chk("lit.blink_b_dot0", dot_b, 0);
    adv(4);
    chk("lit.blink_b_dot1", dot_b, 1);
    chk("lit.blink_a_dot", dot_a, 0);
    adv(32);

    @(negedge clk);
    dot_mode = 2'b11;
    adv(16);
    @(negedge clk);
    dot_mode = 2'b00;
    adv(16);

    // Mid-frame reset while a shows led = 10, x = 3.
    for (int k = 0; k < 64 && m_led[0] != 2'd2; k++) @(negedge clk);
    if (m_led[0] != 2'd2) @(negedge clk);
    chk("lit.pre_rst_led", led_a, 2);
    chk("lit.pre_rst_x", x_a, 3);
    rst = 1'b1;
    @(posedge clk);
    #2;
    chk("lit.rst_led", led_a, 0);
    chk("lit.rst_x", x_a, 0);
    chk("lit.rst_dot", dot_a, 0);
    @(negedge clk);
    rst = 1'b0;
    adv(3);
    chk("lit.rst_hold_led", led_a, 0);
    adv(1);
    chk("lit.rst_step_led", led_a, 1);
    chk("lit.rst_step_x", x_a, 0);
    adv(12);
    chk("lit.rst_wrap_x", x_a, 1);

    // Random digits (including 10..15), modes and occasional resets.
    repeat (16000) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 3))
          0: hr_tens   = 4'($urandom_range(0, 15));
          1: hr_units  = 4'($urandom_range(0, 15));
          2: min_tens  = 4'($urandom_range(0, 15));
          default: min_units = 4'($urandom_range(0, 15));
        endcase
      end
      if ($urandom_range(0, 63) == 0) dot_mode = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 2999) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    adv(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
